// File: rtl/serial_receiver_pkg.sv
// Shared serial definitions: baud default and receiver FSM states, visible to RTL and benches.
package serial_receiver_pkg;

    // 48 MHz clock at 115200 baud
    localparam int unsigned DEFAULT_CLOCKS_PER_BIT = 417;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for an asynchronous level input, with a configurable reset value.
module input_synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q   <= RESET_VALUE;
            sync_out <= RESET_VALUE;
        end else begin
            meta_q   <= async_in;
            sync_out <= meta_q;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first assembly, one-entry valid/ready output buffer.
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_overrun,
    output logic       rx_framing_error
);

    localparam int unsigned HALF = CLOCKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLOCKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);

    logic            rx_sync;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      bit_index_q, bit_index_d;
    logic [7:0]      shift_q, shift_d;
    logic            half_point;
    logic            bit_end;
    logic            deliver;
    logic            frame_error;

    input_synchronizer #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (serial_rx),
        .sync_out (rx_sync)
    );

    assign half_point = (count_q == HALF_LAST);
    assign bit_end    = (count_q == BIT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_sync) begin
                    state_d = START;
                end
            end
            START: begin
                // A start bit that is high at mid-point was a glitch
                if (half_point) begin
                    state_d = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_index_q == 3'd7)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = rx_sync ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        count_d     = '0;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_error = 1'b0;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
            end
            START: begin
                if (half_point) begin
                    bit_index_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d     = {rx_sync, shift_q[7:1]};
                    bit_index_d = bit_index_q + 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    deliver     = rx_sync;
                    frame_error = !rx_sync;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            BREAK: begin
                count_d = '0;
            end
            default: begin
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q          <= '0;
            bit_index_q      <= '0;
            shift_q          <= '0;
            rx_data          <= 8'h00;
            rx_data_valid    <= 1'b0;
            rx_overrun       <= 1'b0;
            rx_framing_error <= 1'b0;
        end else begin
            count_q          <= count_d;
            bit_index_q      <= bit_index_d;
            shift_q          <= shift_d;
            rx_overrun       <= 1'b0;
            rx_framing_error <= frame_error;
            if (deliver) begin
                // A same-edge consume frees the slot for the new byte
                if (!rx_data_valid || rx_data_ready) begin
                    rx_data       <= shift_q;
                    rx_data_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

endmodule
